// File: rtl/updown_counter_param_if.sv
// Control and status bundle for updown_counter_param.
// master drives the controls and observes status; slave is the counter side.
interface updown_counter_param_if #(
  parameter int WIDTH = 8
);
  logic             clear;
  logic             load;
  logic [WIDTH-1:0] load_value;
  logic             enable;
  logic             direction;
  logic [WIDTH-1:0] step;
  logic [WIDTH-1:0] cmp_value;
  logic [WIDTH-1:0] count;
  logic             terminal;
  logic             match;
  logic             at_max;
  logic             at_min;

  modport master (
    output clear, load, load_value, enable, direction, step, cmp_value,
    input  count, terminal, match, at_max, at_min
  );

  modport slave (
    input  clear, load, load_value, enable, direction, step, cmp_value,
    output count, terminal, match, at_max, at_min
  );
endinterface

// File: rtl/updown_counter_param.sv
// Parametrised up/down counter over 0..MAX_VAL with programmable step,
// wrap-or-saturate ends, and registered terminal/compare flags.
module updown_counter_param #(
  parameter int              WIDTH    = 8,
  parameter longint unsigned MAX_VAL  = (64'd1 << WIDTH) - 64'd1,
  parameter bit              SATURATE = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  updown_counter_param_if.slave bus
);
  // One spare bit so count+step and count+modulus never overflow, even at WIDTH=32.
  localparam logic [WIDTH:0] MAXV = (WIDTH+1)'(MAX_VAL);
  localparam logic [WIDTH:0] MOD  = MAXV + (WIDTH+1)'(1);

  logic [WIDTH-1:0] count_q, count_d;
  logic             term_q, term_d;
  logic             match_q;
  logic [WIDTH:0]   cur, s, lv, up_sum, wrap_base;

  always_comb begin
    cur       = {1'b0, count_q};
    s         = ({1'b0, bus.step} > MAXV) ? MAXV : {1'b0, bus.step};
    lv        = ({1'b0, bus.load_value} > MAXV) ? MAXV : {1'b0, bus.load_value};
    up_sum    = cur + s;
    wrap_base = cur + MOD;
    count_d   = count_q;
    term_d    = 1'b0;
    if (bus.clear) begin
      count_d = '0;
    end else if (bus.load) begin
      count_d = WIDTH'(lv);
    end else if (bus.enable) begin
      if (bus.direction) begin
        if (up_sum <= MAXV) begin
          count_d = WIDTH'(up_sum);
        end else begin
          term_d  = 1'b1;
          count_d = SATURATE ? WIDTH'(MAXV) : WIDTH'(up_sum - MOD);
        end
      end else begin
        if (s <= cur) begin
          count_d = WIDTH'(cur - s);
        end else begin
          term_d  = 1'b1;
          count_d = SATURATE ? '0 : WIDTH'(wrap_base - s);
        end
      end
    end
  end

  // match is registered against the next count so it lines up with count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      term_q  <= 1'b0;
      match_q <= 1'b0;
    end else begin
      count_q <= count_d;
      term_q  <= term_d;
      match_q <= (count_d == bus.cmp_value);
    end
  end

  assign bus.count    = count_q;
  assign bus.terminal = term_q;
  assign bus.match    = match_q;
  assign bus.at_max   = (count_q == WIDTH'(MAXV));
  assign bus.at_min   = (count_q == '0);
endmodule
